// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package rv32m_muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation. Turns signed operands into
// magnitudes on the way in and restores the sign of results on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a final sign fix-up.
// Divide-by-zero and signed overflow bypass the iteration.
module rv32m_muldiv_unit
  import rv32m_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [CW-1:0]       count_q, count_d;
  // Multiply: {partial product hi, multiplier}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                fast_q, fast_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   prod_fixed;
  logic [XLEN-1:0]     quo_fixed, rem_fixed, final_res;

  // Decode operand signedness and the fast-path cases from the live inputs.
  always_comb begin
    sign_a   = rs1_data[XLEN-1] & ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                                   (funct3 == F3_DIV)  || (funct3 == F3_REM));
    sign_b   = rs2_data[XLEN-1] & ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                                   (funct3 == F3_REM));
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_data == INT_MIN) && (rs2_data == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) fast_res = funct3[1] ? rs1_data : '1;
    else          fast_res = funct3[1] ? '0 : INT_MIN;
  end

  muldiv_sign_fix #(.W(XLEN)) u_mag_a (
    .value_i (rs1_data),
    .negate_i(sign_a),
    .value_o (mag_a)
  );

  muldiv_sign_fix #(.W(XLEN)) u_mag_b (
    .value_i (rs2_data),
    .negate_i(sign_b),
    .value_o (mag_b)
  );

  // One iteration of either algorithm, computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .value_i (acc_q),
    .negate_i(sign_a_q ^ sign_b_q),
    .value_o (prod_fixed)
  );

  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .value_i (acc_q[XLEN-1:0]),
    .negate_i(sign_a_q ^ sign_b_q),
    .value_o (quo_fixed)
  );

  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .value_i (acc_q[2*XLEN-1:XLEN]),
    .negate_i(sign_a_q),
    .value_o (rem_fixed)
  );

  // Pick the architectural result for the latched op.
  always_comb begin
    final_res = '0;
    case (f3_q)
      F3_MUL:                         final_res = prod_fixed[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   final_res = prod_fixed[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                final_res = quo_fixed;
      default:                        final_res = rem_fixed;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    f3_d     = f3_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    fast_d   = fast_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d     = funct3;
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          opb_d    = mag_b;
          count_d  = '0;
          if (div_zero || div_ovf) begin
            fast_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, fast_res};
            state_d = FINISH;
          end else begin
            fast_d  = 1'b0;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (f3_q[2]) begin
          // Restoring step: keep the subtraction only if it did not borrow.
          if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                  acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) state_d = FINISH;
      end

      FINISH: begin
        result_d = fast_q ? acc_q[XLEN-1:0] : final_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      fast_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      fast_q   <= fast_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits beside the combinational ALU. The core issues M-extension ops to it over a start/busy/done handshake, and the unit returns the 32-bit result after a fixed multi-cycle latency. Multiplies use shift-add and divides use restoring division, both operating on operand magnitudes with a final sign fix-up. Division-by-zero and signed-overflow cases take a 1-cycle fast path.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  input  XLEN  operand A (multiplicand/dividend).
rs2_data  input  XLEN  operand B (multiplier/divisor).
busy  output  1  operation in progress; start is ignored while high.
done  output  1  one-cycle pulse; result is valid in the same cycle.
result  output  XLEN  registered result; holds its value until the next done.

Behaviour:
- Reset (synchronous, active-high) sets state=IDLE, busy=0, done=0, result=0, and clears the counter and datapath registers.
- rst asserted mid-operation aborts the op and applies the same reset values. No done is produced for the aborted op.
- States: IDLE, CALC, FINISH.
- IDLE, on edge E0 with start=1:
  - Latch funct3.
  - Compute operand signs: signed for MULH/DIV/REM; rs1 only for MULHSU; none for the unsigned ops and MUL.
  - Compute magnitudes.
  - Set busy=1.
- Fast path, decided at E0:
  - Divisor=0: DIV/DIVU give all-ones; REM/REMU give rs1_data.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - Fast-path ops go directly to FINISH, so done rises after E1 (latency 1).
- Normal path, E0 to CALC with count=0:
  - Edges E1..E32 each perform one iteration.
  - Multiply: 64-bit accumulator, add when the multiplier LSB is 1, then shift.
  - Divide: restoring step on {remainder, quotient}, one quotient bit per edge.
  - At count=XLEN-1, go to FINISH.
- FINISH, on edge E33 for the normal path:
  - Apply sign fix-up, written into result.
  - Set done=1, busy=0, state=IDLE.
  - Latency is XLEN+1 = 33 cycles from the start edge to done.
- Sign fix-up:
  - Product is negated (two's complement, 64-bit) when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32]; DIV/DIVU give the quotient; REM/REMU give the remainder.
- done is high for exactly one cycle.
- start may be asserted in the cycle done is high, since busy=0 in that cycle. It is accepted at the next edge, giving back-to-back ops with no bubble.
- start while busy=1 is ignored. Operand changes while busy do not affect the op in flight.
- Operands are captured at E0 only. Callers need not hold them stable afterwards.

Decomposition:
- Shared package holds:
  - funct3 localparams: F3_MUL … F3_REMU.
  - State encoding: IDLE/CALC/FINISH.
  - XLEN default.
- One natural sub-module, muldiv_sign_fix: combinational magnitude conversion and result negation, reused at both ends of the datapath.
- The iterative core stays in the top module.

Test Plan:
- MUL 7 × −3 (rs1=0x7, rs2=0xFFFFFFFD) -> done exactly 33 cycles after start, result=0xFFFFFFEB, busy=1 during cycles 1..32.
- MULH 0x80000000 × 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done 1 cycle after start. REM 5/0 -> 5. DIV 0x80000000/−1 -> 0x80000000 with latency 1.
- Second start pulsed mid-op (cycle 10) with different operands -> ignored, first result unchanged. start in the done cycle -> second op done 33 cycles later.
- rst asserted at cycle 15 of a DIV -> next cycle busy=0, done=0, result=0. No done pulse follows. A fresh op afterwards completes correctly.
